// File: rtl/fifo_mem_ctrl.sv
// Synchronous FIFO controller for an external simple dual-port memory with registered read.
// Optional sticky overflow/underflow flags are enabled by defining FIFO_CTRL_ERR_FLAGS_EN.
module fifo_mem_ctrl #(
   parameter int unsigned DEPTH     = 1024,
   parameter int unsigned AW        = 10,
   parameter int unsigned DW        = 18,
   parameter int unsigned RD_LAT    = 2,
   parameter int unsigned AFULL_TH  = 1020,
   parameter int unsigned AEMPTY_TH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [DW-1:0] wdata,
   input  logic          pop,
   output logic [DW-1:0] rdata,
   output logic          rdata_vld,
   output logic          full,
   output logic          empty,
   output logic          afull,
   output logic          aempty,
   output logic [AW:0]   count,
   output logic [AW-1:0] mem_waddr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   output logic [AW-1:0] mem_raddr,
   output logic          mem_re,
   input  logic [DW-1:0] mem_q
`ifdef FIFO_CTRL_ERR_FLAGS_EN
   ,
   output logic          ovf,
   output logic          udf
`endif
);

   if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
      $error("fifo_mem_ctrl: RD_LAT must be 1 or 2");
   end

   localparam logic [AW-1:0] LastAddr  = AW'(DEPTH - 1);
   localparam logic [AW:0]   DepthCnt  = (AW+1)'(DEPTH);
   localparam logic [AW:0]   AfullCnt  = (AW+1)'(AFULL_TH);
   localparam logic [AW:0]   AemptyCnt = (AW+1)'(AEMPTY_TH);

   logic [AW-1:0]     wptr_q, wptr_d;
   logic [AW-1:0]     rptr_q, rptr_d;
   logic [AW:0]       count_q, count_d;
   logic              full_q, full_d;
   logic              empty_q, empty_d;
   logic              afull_q, afull_d;
   logic              aempty_q, aempty_d;
   logic [RD_LAT-1:0] vld_q, vld_d;
   logic              wr_ok, rd_ok;

   // Gated by rst_n so the memory sees no write while reset is held.
   assign wr_ok = push & ~full_q & rst_n;
   assign rd_ok = pop & ~empty_q & rst_n;

   always_comb begin
      wptr_d = wptr_q;
      if (wr_ok) wptr_d = (wptr_q == LastAddr) ? '0 : wptr_q + AW'(1);
      rptr_d = rptr_q;
      if (rd_ok) rptr_d = (rptr_q == LastAddr) ? '0 : rptr_q + AW'(1);

      count_d = count_q;
      if (wr_ok && !rd_ok)      count_d = count_q + (AW+1)'(1);
      else if (rd_ok && !wr_ok) count_d = count_q - (AW+1)'(1);

      full_d   = (count_d == DepthCnt);
      empty_d  = (count_d == '0);
      afull_d  = (count_d >= AfullCnt);
      aempty_d = (count_d <= AemptyCnt);

      // Lower RD_LAT bits of {vld_q, rd_ok}: a plain shift-in of rd_ok.
      vld_d = RD_LAT'({vld_q, rd_ok});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         afull_q  <= 1'b0;
         aempty_q <= 1'b1;
         vld_q    <= '0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         afull_q  <= afull_d;
         aempty_q <= aempty_d;
         vld_q    <= vld_d;
      end
   end

   assign mem_we    = wr_ok;
   assign mem_waddr = wptr_q;
   assign mem_wdata = wdata;
   assign mem_re    = rd_ok;
   assign mem_raddr = rptr_q;

   assign rdata     = mem_q;
   assign rdata_vld = vld_q[RD_LAT-1];
   assign full      = full_q;
   assign empty     = empty_q;
   assign afull     = afull_q;
   assign aempty    = aempty_q;
   assign count     = count_q;

`ifdef FIFO_CTRL_ERR_FLAGS_EN
   logic ovf_q, ovf_d;
   logic udf_q, udf_d;

   always_comb begin
      ovf_d = ovf_q | (push & full_q);
      udf_d = udf_q | (pop & empty_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   assign ovf = ovf_q;
   assign udf = udf_q;
`endif

endmodule
